ssd_capture: RTL

Receive side of the seven-segment display path. Monitors the multiplexed segment/digit-select drive of the two-digit Pmod SSD and reconstructs the hex value shown on each digit position. Used as an on-chip readback and self-check of the display path: roller core → segment encoder → pins, looped back into this block. It waits for a pattern to settle, decodes it back to a nibble, holds per-digit results, and flags unrecognised patterns.

---
 rtl/ssd_pkg.sv | 52 +++++
 rtl/ssd_capture_pattern_decode.sv | 41 ++++
 rtl/ssd_capture.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared seven-segment glyph table and capture FSM encoding.
// Encoder and capture decoder both draw their patterns from here.
package ssd_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1110011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    TRACK = 1'b0,
    HOLD  = 1'b1
  } cap_state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] s;
    s = SEG_BLANK;
    case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ssd_capture_pattern_decode.sv
// Combinational segment pattern to nibble decoder.
// hit marks a hex glyph; is_blank marks the all-off pattern.
module ssd_pattern_decode
  import ssd_pkg::*;
(
  input  logic [6:0] pat,
  output logic       hit,
  output logic       is_blank,
  output logic [3:0] nibble
);

  always_comb begin
    hit      = 1'b1;
    is_blank = 1'b0;
    nibble   = 4'h0;
    case (pat)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_6: nibble = 4'h6;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
      SEG_A: nibble = 4'hA;
      SEG_B: nibble = 4'hB;
      SEG_C: nibble = 4'hC;
      SEG_D: nibble = 4'hD;
      SEG_E: nibble = 4'hE;
      SEG_F: nibble = 4'hF;
      SEG_BLANK: begin
        hit      = 1'b0;
        is_blank = 1'b1;
      end
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_capture.sv
// Settle-and-capture readback of the two-digit multiplexed display.
// Optional SSD_CAP_ERR_CNT_EN adds a saturating err_count output.
module ssd_capture
  import ssd_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       sel_in,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [1:0] valid,
  output logic [1:0] blank,
  output logic       update,
  output logic       err
`ifdef SSD_CAP_ERR_CNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

  cap_state_e      state_q, state_d;
  logic [7:0]      samp_q, samp_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            primed_q, primed_d;
  logic [1:0][3:0] dig_q, dig_d;
  logic [1:0]      valid_q, valid_d;
  logic [1:0]      blank_q, blank_d;
  logic            update_q, update_d;
  logic            err_q, err_d;

  logic [7:0] samp_in;
  logic       changed;
  logic       capture;
  logic       pos;
  logic       dec_hit;
  logic       dec_blank;
  logic [3:0] dec_nib;

  ssd_pattern_decode u_dec (
    .pat      (samp_q[6:0]),
    .hit      (dec_hit),
    .is_blank (dec_blank),
    .nibble   (dec_nib)
  );

  assign samp_in = {sel_in, seg_in};
  // Unprimed sample register forces a load on the first edge out of reset.
  assign changed = !primed_q || (samp_in != samp_q);
  assign pos     = samp_q[7];

  always_comb begin
    state_d  = state_q;
    samp_d   = samp_q;
    cnt_d    = cnt_q;
    primed_d = 1'b1;
    dig_d    = dig_q;
    valid_d  = valid_q;
    blank_d  = blank_q;
    update_d = 1'b0;
    err_d    = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      TRACK: begin
        if (changed) begin
          samp_d = samp_in;
          cnt_d  = 8'd0;
        end else if (cnt_q == LAST) begin
          capture = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (changed) begin
          samp_d  = samp_in;
          cnt_d   = 8'd0;
          state_d = TRACK;
        end
      end
    endcase
    if (capture) begin
      if (dec_hit) begin
        dig_d[pos]   = dec_nib;
        valid_d[pos] = 1'b1;
        blank_d[pos] = 1'b0;
      end else if (dec_blank) begin
        blank_d[pos] = 1'b1;
        valid_d[pos] = 1'b0;
      end else begin
        err_d = 1'b1;
      end
      update_d = (dig_d != dig_q) || (valid_d != valid_q)
              || (blank_d != blank_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= TRACK;
      samp_q   <= 8'd0;
      cnt_q    <= 8'd0;
      primed_q <= 1'b0;
      dig_q    <= '0;
      valid_q  <= 2'b00;
      blank_q  <= 2'b00;
      update_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      samp_q   <= samp_d;
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
      dig_q    <= dig_d;
      valid_q  <= valid_d;
      blank_q  <= blank_d;
      update_q <= update_d;
      err_q    <= err_d;
    end
  end

  assign digit0 = dig_q[0];
  assign digit1 = dig_q[1];
  assign valid  = valid_q;
  assign blank  = blank_q;
  assign update = update_q;
  assign err    = err_q;

`ifdef SSD_CAP_ERR_CNT_EN
  logic [7:0] errc_q, errc_d;

  always_comb begin
    errc_d = errc_q;
    if (err_d && (errc_q != 8'hFF)) errc_d = errc_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) errc_q <= 8'd0;
    else     errc_q <= errc_d;
  end

  assign err_count = errc_q;
`endif

endmodule
